// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// Holds the FSM states, the memory size codes and the RV32I load/store funct3 values.
package lsu_pkg;

  localparam int BUS_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of a load/store request into access size, extension mode
// and the two error conditions (illegal funct3, misaligned address).
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output size_e      size,
  output logic       sz_ex,
  output logic       illegal,
  output logic       misaligned
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    size    = SZ_BYTE;
    sz_ex   = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_B:    begin size = SZ_BYTE; sz_ex = ~we; end
      F3_H:    begin size = SZ_HALF; sz_ex = ~we; end
      F3_W:    begin size = SZ_WORD; sz_ex = ~we; end
      F3_BU:   begin size = SZ_BYTE; illegal = we; end
      F3_HU:   begin size = SZ_HALF; illegal = we; end
      default: illegal = 1'b1;
    endcase
  end

  assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, drives the data memory
// port for RD_LAT cycles (or skips it on an error) and holds the response until consumed.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BUS_WIDTH-1:0] d_mem_address,
  output logic [BUS_WIDTH-1:0] d_mem_wr_data,
  output logic                 d_mem_wr_en,
  output logic [1:0]           d_mem_size,
  output logic                 d_mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] d_mem_rd_data
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e               state, state_next;
  logic [1:0]           cnt;
  logic [BUS_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                 we_q, sz_ex_q, err_q;
  size_e                size_q;

  size_e dec_size;
  logic  dec_sz_ex, dec_illegal, dec_misaligned, dec_err, accept;

  lsu_decode u_decode (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .size       (dec_size),
    .sz_ex      (dec_sz_ex),
    .illegal    (dec_illegal),
    .misaligned (dec_misaligned)
  );

  assign dec_err = dec_illegal | dec_misaligned;
  assign accept  = req_valid && (state == IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = dec_err ? RESP : ISSUE;
      ISSUE:   if (cnt == 2'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt     <= CNT_INIT;
        rdata_q <= '0;
        err_q   <= dec_err;
      end else if (state == ISSUE) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else if (!we_q)  rdata_q <= d_mem_rd_data;
      end
    end
  end

  // NOTE: request fields carry no reset; they are only observed while the FSM is in ISSUE, which requires a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
      size_q  <= dec_size;
      sz_ex_q <= dec_sz_ex;
    end
  end

  always_comb begin
    d_mem_address = '0;
    d_mem_wr_data = '0;
    d_mem_wr_en   = 1'b0;
    d_mem_size    = 2'b00;
    d_mem_sz_ex   = 1'b0;
    if (state == ISSUE) begin
      d_mem_address = addr_q;
      d_mem_wr_data = wdata_q;
      d_mem_size    = size_q;
      d_mem_sz_ex   = sz_ex_q;
      // The counter still holds its load value only during the first ISSUE cycle.
      d_mem_wr_en   = we_q && (cnt == CNT_INIT);
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
